lut_truth_table_sweeper: RTL and testbench

Sequential characteriser for the generated LUT neurons. Drives every input code 0 … 2^IN_BITS−1 onto a neuron's input bus, samples the neuron output, packs the results into words and streams the complete truth table out on a valid/ready interface. It sits in the build-verification harness beside each synthesised neuron and recovers the table the neuron implements, for comparison against the trained model.

---
 rtl/lut_sweep_pkg.sv | 25 ++
 rtl/lut_sweep_crc16.sv | 38 +++
 rtl/lut_truth_table_sweeper.sv | 141 ++++++++++++++
 tb/tb_lut_truth_table_sweeper.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_sweep_pkg.sv
`default_nettype none
// lut_sweep_pkg: state encoding, CRC-16-CCITT constants and table sizing helpers for the LUT sweeper. Rev 1.0
package lut_sweep_pkg;

  typedef logic [2:0] sweep_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_EMIT    = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int num_entries(input int in_bits);
    return 1 << in_bits;
  endfunction

  function automatic int num_words(input int in_bits, input int out_bits, input int word_w);
    return (num_entries(in_bits) * out_bits) / word_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_sweep_crc16.sv
`default_nettype none
// lut_sweep_crc16: word-serial CRC-16-CCITT (no reflection, no final XOR), word consumed LSB first. Rev 1.0
module lut_sweep_crc16
  import lut_sweep_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              update,
  input  logic [WORD_W-1:0] data,
  output logic [15:0]       crc
);

  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < WORD_W; i++) begin
      if (crc_next[15] ^ data[i]) begin
        crc_next = {crc_next[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_next = {crc_next[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      crc <= CRC_INIT;
    end else if (update) begin
      crc <= crc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lut_truth_table_sweeper.sv
`default_nettype none
// lut_truth_table_sweeper: drives every neuron input code, packs the sampled outputs and streams the truth table. Rev 1.0
// Defining LUT_SWEEP_SIG_EN adds a CRC-16-CCITT signature of the emitted stream on the sig port.
module lut_truth_table_sweeper
  import lut_sweep_pkg::*;
#(
  parameter int IN_BITS    = 8,
  parameter int OUT_BITS   = 1,
  parameter int WORD_W     = 32,
  parameter int SAMPLE_LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_BITS-1:0]  probe_addr,
  input  logic [OUT_BITS-1:0] probe_data,
  output logic [WORD_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast
`ifdef LUT_SWEEP_SIG_EN
  ,
  output logic [15:0]         sig
`endif
);

  localparam int ENTRIES    = num_entries(IN_BITS);
  localparam int NUM_WORDS  = num_words(IN_BITS, OUT_BITS, WORD_W);
  localparam int SLOTS      = WORD_W / OUT_BITS;
  localparam int CNT_W      = IN_BITS + 1;
  localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WORD_IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LAT_W      = (SAMPLE_LAT > 1) ? $clog2(SAMPLE_LAT) : 1;
  // With no sample latency the settle phase is skipped entirely, so a launch goes straight to capture.
  localparam sweep_state_t ST_AFTER_LAUNCH = (SAMPLE_LAT == 0) ? ST_CAPTURE : ST_SETTLE;

  sweep_state_t          state;
  logic [CNT_W-1:0]      addr_cnt;
  logic [SLOT_W-1:0]     slot;
  logic [WORD_IDX_W-1:0] word_idx;
  logic [LAT_W-1:0]      lat_cnt;
  logic [WORD_W-1:0]     pack;
  logic                  word_full;
  logic                  last_word;
  logic                  start_ok;
  logic                  handshake;

  assign word_full = (slot == SLOT_W'(SLOTS - 1));
  assign last_word = (word_idx == WORD_IDX_W'(NUM_WORDS - 1));
  assign start_ok  = (state == ST_IDLE) && start;
  assign handshake = (state == ST_EMIT) && m_tready;

  assign busy       = (state == ST_SETTLE) || (state == ST_CAPTURE) || (state == ST_EMIT);
  assign done       = (state == ST_FINISH);
  assign m_tvalid   = (state == ST_EMIT);
  assign m_tlast    = (state == ST_EMIT) && last_word;
  assign m_tdata    = pack;
  assign probe_addr = addr_cnt[IN_BITS-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_cnt <= '0;
      slot     <= '0;
      word_idx <= '0;
      lat_cnt  <= '0;
      pack     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_cnt <= '0;
            slot     <= '0;
            word_idx <= '0;
            lat_cnt  <= '0;
            pack     <= '0;
            state    <= ST_AFTER_LAUNCH;
          end
        end
        ST_SETTLE: begin
          if (lat_cnt == LAT_W'(SAMPLE_LAT - 1)) begin
            lat_cnt <= '0;
            state   <= ST_CAPTURE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          // The packer is cleared at each word boundary, so OR-ing in the new slot is enough.
          pack <= pack | (WORD_W'(probe_data) << (slot * OUT_BITS));
          if (word_full) begin
            state <= ST_EMIT;
          end else begin
            addr_cnt <= addr_cnt + 1'b1;
            slot     <= slot + 1'b1;
            state    <= ST_AFTER_LAUNCH;
          end
        end
        ST_EMIT: begin
          if (m_tready) begin
            if (last_word) begin
              state <= ST_FINISH;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
              slot     <= '0;
              word_idx <= word_idx + 1'b1;
              pack     <= '0;
              state    <= ST_AFTER_LAUNCH;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LUT_SWEEP_SIG_EN
  lut_sweep_crc16 #(
    .WORD_W (WORD_W)
  ) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (start_ok),
    .update (handshake),
    .data   (pack),
    .crc    (sig)
  );
`else
  logic unused_ctl;
  assign unused_ctl = start_ok ^ handshake;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lut_truth_table_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// tb_lut_truth_table_sweeper: randomized scoreboard bench for the LUT truth-table sweeper.
module tb_lut_truth_table_sweeper;

  localparam int ENTRIES = 256;
  localparam int NWORDS  = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1, m_tready;
  logic [7:0]  probe_addr0, probe_addr1;
  logic        probe_data0, probe_data1;
  logic        busy0, done0, valid0, last0;
  logic        busy1, done1, valid1, last1;
  logic [31:0] data0, data1;
  logic [15:0] sig0, sig1;

  logic tbl0 [ENTRIES];
  logic tbl1 [ENTRIES];
  logic nr1, nr2;

  // dut0: combinational neuron; dut1: neuron with a two-stage registered output
  assign probe_data0 = tbl0[probe_addr0];
  always @(posedge clk) begin
    nr1 <= tbl1[probe_addr1];
    nr2 <= nr1;
  end
  assign probe_data1 = nr2;

  lut_truth_table_sweeper dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .probe_addr(probe_addr0), .probe_data(probe_data0),
    .m_tdata(data0), .m_tvalid(valid0), .m_tready(m_tready), .m_tlast(last0)
`ifdef LUT_SWEEP_SIG_EN
    , .sig(sig0)
`endif
  );

  lut_truth_table_sweeper #(.SAMPLE_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .probe_addr(probe_addr1), .probe_data(probe_data1),
    .m_tdata(data1), .m_tvalid(valid1), .m_tready(m_tready), .m_tlast(last1)
`ifdef LUT_SWEEP_SIG_EN
    , .sig(sig1)
`endif
  );

`ifndef LUT_SWEEP_SIG_EN
  assign sig0 = 16'hFFFF;
  assign sig1 = 16'hFFFF;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  beat_t       q[$];
  logic [15:0] gold_sig;
  bit          stall [2];
  int          stall_cycles [2];
  int          beats [2];
  logic [31:0] hold_d [2];
  logic [7:0]  hold_a [2];
  int          ready_mode = 0;
  bit          stalled = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 32; i++) begin
      fb = r[15] ^ w[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic fill(input int w, input int kind);
    logic b;
    for (int a = 0; a < ENTRIES; a++) begin
      case (kind)
        0:       b = 1'b1;
        1:       b = logic'(a % 2);
        2:       b = logic'(a / 128);
        default: b = logic'($urandom_range(0, 1));
      endcase
      if (w == 0) tbl0[a] = b; else tbl1[a] = b;
    end
  endtask

  // Reference: word k holds table entries 32k..32k+31, entry 32k at bit 0.
  task automatic build_expect(input int w);
    logic [31:0] word;
    q.delete();
    gold_sig = 16'hFFFF;
    for (int k = 0; k < NWORDS; k++) begin
      word = '0;
      for (int i = 0; i < 32; i++) word[i] = (w == 0) ? tbl0[k*32+i] : tbl1[k*32+i];
      q.push_back('{word, (k == NWORDS - 1)});
      gold_sig = crc_word(gold_sig, word);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic [31:0] d, input logic l,
                     input logic [7:0] a, input logic dn, input logic b, input logic [15:0] s);
    beat_t e;
    if (!rst_n) begin
      stall[w] = 1'b0;
      return;
    end
    if (stall[w]) begin
      stall_cycles[w]++;
      check($sformatf("hold_valid%0d", w), v, 1);
      check($sformatf("hold_data%0d", w), d, hold_d[w]);
      check($sformatf("hold_addr%0d", w), a, hold_a[w]);
    end
    stall[w]  = v && !m_tready;
    hold_d[w] = d;
    hold_a[w] = a;
    if (v && m_tready) begin
      beats[w]++;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat%0d: got data %h, required no beat", w, d);
      end else begin
        e = q.pop_front();
        check($sformatf("beat_data%0d", w), d, e.data);
        check($sformatf("beat_last%0d", w), l, e.last);
      end
    end
    if (dn) begin
      check($sformatf("done_busy%0d", w), b, 0);
      check($sformatf("done_pending%0d", w), q.size(), 0);
`ifdef LUT_SWEEP_SIG_EN
      check($sformatf("sig%0d", w), s, gold_sig);
`else
      if (s !== 16'hFFFF) check($sformatf("sig_tie%0d", w), s, 16'hFFFF);
`endif
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid0, data0, last0, probe_addr0, done0, busy0, sig0);
    mon(1, valid1, data1, last1, probe_addr1, done1, busy1, sig1);
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: m_tready = ($urandom_range(0, 2) != 0);
        2: begin
          if (valid0 && beats[0] == 2 && !stalled) begin
            stalled  = 1'b1;
            m_tready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
          end
          m_tready = 1'b1;
        end
        default: m_tready = 1'b1;
      endcase
    end
  end

  task automatic run_sweep(input int w, input int rmode, input int exp_cyc, input bit pulse);
    int n;
    bit got;
    bit sv;
    build_expect(w);
    beats[w] = 0;
    stall_cycles[w] = 0;
    stalled = 1'b0;
    ready_mode = rmode;
    @(posedge clk);
    #1;
    if (w == 0) start0 = 1'b1; else start1 = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if ((w == 0) ? done0 : done1) begin
        got = 1'b1;
        break;
      end
      // Extra starts while busy (and through the final beat into FINISH) must be ignored.
      sv = pulse && (($urandom_range(0, 7) == 0) || ((w == 0) ? (valid0 && last0) : (valid1 && last1)));
      if (w == 0) start0 = sv; else start1 = sv;
      if (n == 1) check($sformatf("busy_after_start%0d", w), (w == 0) ? busy0 : busy1, 1);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL sweep_timeout%0d: got no done within %0d cycles, required done", w, n);
    end else if (exp_cyc > 0) begin
      check($sformatf("done_latency%0d", w), n, exp_cyc);
    end
    @(posedge clk);
    #1;
    check($sformatf("done_pulse%0d", w), (w == 0) ? done0 : done1, 0);
    check($sformatf("idle_after_finish%0d", w), (w == 0) ? busy0 : busy1, 0);
    ready_mode = 0;
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_valid", valid0, 0);
    check("rst_last", last0, 0);
    check("rst_data", data0, 0);
    check("rst_addr", probe_addr0, 0);
    check("rst_sig", sig0, 16'hFFFF);
    check("rst_valid1", valid1, 0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    fill(0, 0);
    fill(1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    fill(0, 0); run_sweep(0, 0, 265, 1'b0);
    fill(0, 1); run_sweep(0, 0, 265, 1'b0);
    fill(0, 2); run_sweep(0, 0, 265, 1'b1);
    fill(0, 3); run_sweep(0, 2, 0, 1'b0);
    check("stall_cycles", stall_cycles[0], 5);
    fill(0, 3); run_sweep(0, 1, 0, 1'b1);

    // Each entry costs launch + two settle cycles: 256*3 + 8 emits + finish.
    fill(1, 3); run_sweep(1, 0, 777, 1'b0);
    fill(1, 3); run_sweep(1, 1, 0, 1'b1);

    // Reset in the middle of word 3, then sweep again.
    fill(0, 3);
    build_expect(0);
    beats[0] = 0;
    @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    n = 0;
    while (probe_addr0 != 8'd100 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_addr100", probe_addr0, 100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    check_reset_values();
    check("beats_before_reset", beats[0], 3);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_beat_after_reset", beats[0], 3);
    check("idle_after_reset", busy0, 0);
    run_sweep(0, 1, 0, 1'b0);
    check("full_sweep_after_reset", beats[0], NWORDS);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
